// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment lookup for the 7-segment display path.
// Purely combinational content, so there is no latency.
// No flow control: the package holds constants and functions only.
package seg7_pkg;

    localparam int          NDIG      = 4;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [3:0]  AN_OFF    = 4'hF;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low 7-segment pattern; kept as a module so other displays can reuse it.
// Combinational, zero cycles of latency.
// No flow control: output follows input continuously.
// Ports: nib (4-bit hex digit in), seg (7-bit {g,f,e,d,c,b,a} active-low out).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_hex_display.sv
// Time-multiplexed 4-digit hex display of a 16-bit word with per-frame snapshot and leading-zero blanking.
// Pins are registered and lag the scan index by one cycle; a new value reaches the pins within 4*DIV+1 cycles.
// No flow control: value is sampled only at frame boundaries, changes in between are ignored.
// Ports: clk, rst (sync, active-high), value[15:0], en, dp_mask[3:0] in; seg[6:0], dp, an[3:0] out (all active-low).
module seg7_hex_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int DIGIT_HZ      = 1000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        en,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("seg7_hex_display: CLK_HZ/DIGIT_HZ must be at least 2");
    end

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic          tick;
    logic [3:0]    nib;
    logic [15:0]   lead;
    logic          blank;
    logic [6:0]    hex_seg;
    logic [3:0]    an_sel;

    assign tick   = (pcnt == PMAX);
    assign nib    = shadow[{idx, 2'b00} +: 4];
    // Current digit and everything above it; all zero means it is a leading zero.
    assign lead   = shadow >> {idx, 2'b00};
    assign blank  = BLANK_LEADING && (idx != 2'd0) && (lead == 16'h0000);
    assign an_sel = ~(4'b0001 << idx);

    seg7_hex_decoder u_dec (
        .nib (nib),
        .seg (hex_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt   <= '0;
            idx    <= 2'd0;
            shadow <= 16'h0000;
            an     <= AN_OFF;
            seg    <= SEG_BLANK;
            dp     <= 1'b1;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Capture only as the last digit finishes so a frame never mixes two words.
            if (tick && idx == 2'd3) begin
                shadow <= value;
            end
            an  <= (en && !blank) ? an_sel : AN_OFF;
            seg <= blank ? SEG_BLANK : hex_seg;
            dp  <= ~(dp_mask[idx] && en && !blank);
        end
    end

endmodule

// File: tb/tb_seg7_hex_display.sv
module tb_seg7_hex_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        en;
    logic [3:0]  dp_mask;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic [3:0]  an, an_nb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_hex_display #(.CLK_HZ(8), .DIGIT_HZ(2), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .en(en), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .an(an)
    );

    seg7_hex_display #(.CLK_HZ(8), .DIGIT_HZ(2), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .en(en), .dp_mask(dp_mask),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks ncyc consecutive cycles of one digit on the selected instance.
    task automatic check_digit(input string name, input bit sel, input int ncyc,
                               input logic [3:0] ea, input logic [6:0] es, input logic ed);
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        for (int c = 0; c < ncyc; c++) begin
            step();
            a = sel ? an_nb  : an;
            s = sel ? seg_nb : seg;
            d = sel ? dp_nb  : dp;
            total++;
            if (a !== ea) begin
                bad++;
                $display("FAIL %s an cyc%0d: got %b want %b", name, c, a, ea);
            end
            total++;
            if (s !== es) begin
                bad++;
                $display("FAIL %s seg cyc%0d: got %h want %h", name, c, s, es);
            end
            total++;
            if (d !== ed) begin
                bad++;
                $display("FAIL %s dp cyc%0d: got %b want %b", name, c, d, ed);
            end
        end
    endtask

    // One full frame; digit d expectations sit at ans[4d+:4], segs[7d+:7], dps[d].
    task automatic check_frame(input string name, input bit sel, input logic [15:0] ans,
                               input logic [27:0] segs, input logic [3:0] dps);
        for (int d = 0; d < 4; d++) begin
            check_digit($sformatf("%s_d%0d", name, d), sel, 4, ans[4*d +: 4], segs[7*d +: 7], dps[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; value = 16'h1234; en = 1'b1; dp_mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold: got an=%b seg=%h dp=%b want 1111 7f 1", an, seg, dp);
            end
        end
        rst = 1'b0;
        check_frame("rst_f0", 0, {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
    endtask

    task automatic test_scan();
        check_frame("scan_f1", 0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
        value = 16'h0050;
        check_frame("scan_f2", 0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
    endtask

    task automatic test_blanking();
        check_frame("blank_0050", 0, {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
        value = 16'h0000;
        check_frame("noblank_0050", 1, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF);
        value = 16'h1234;
        check_frame("blank_0000", 0, {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
    endtask

    task automatic test_snapshot();
        check_digit("tear_d0", 0, 4, 4'hE, 7'h19, 1'b1);
        value = 16'hABCD;
        check_digit("tear_d1", 0, 4, 4'hD, 7'h30, 1'b1);
        check_digit("tear_d2", 0, 4, 4'hB, 7'h24, 1'b1);
        check_digit("tear_d3", 0, 4, 4'h7, 7'h79, 1'b1);
        check_frame("snap_abcd", 0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF);
    endtask

    task automatic test_enable_dp();
        value = 16'hFFFF;
        check_digit("en_on_d0", 0, 2, 4'hE, 7'h21, 1'b1);
        en = 1'b0;
        dp_mask = 4'b0101;
        check_digit("en_off_d0", 0, 2, 4'hF, 7'h21, 1'b1);
        check_digit("en_off_d1", 0, 4, 4'hF, 7'h46, 1'b1);
        check_digit("en_off_d2", 0, 4, 4'hF, 7'h03, 1'b1);
        check_digit("en_off_d3", 0, 4, 4'hF, 7'h08, 1'b1);
        en = 1'b1;
        check_frame("dp_ffff", 0, {4'h7, 4'hB, 4'hD, 4'hE}, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b1010);
    endtask

    task automatic test_reset_mid();
        check_digit("mid_d0", 0, 4, 4'hE, 7'h0E, 1'b0);
        check_digit("mid_d1", 0, 4, 4'hD, 7'h0E, 1'b1);
        check_digit("mid_d2", 0, 2, 4'hB, 7'h0E, 1'b0);
        total++;
        if (dut.pcnt !== 2'd2 || dut.idx !== 2'd2) begin
            bad++;
            $display("FAIL mid_pos: got pcnt=%0d idx=%0d want 2 2", dut.pcnt, dut.idx);
        end
        rst = 1'b1;
        step();
        total++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst_pins: got an=%b seg=%h dp=%b want 1111 7f 1", an, seg, dp);
        end
        total++;
        if (dut.pcnt !== 2'd0 || dut.idx !== 2'd0 || dut.shadow !== 16'h0000) begin
            bad++;
            $display("FAIL mid_rst_state: got pcnt=%0d idx=%0d shadow=%h want 0 0 0000",
                     dut.pcnt, dut.idx, dut.shadow);
        end
        rst = 1'b0;
        check_frame("mid_restart", 0, {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);
    endtask

    initial begin
        rst = 1'b1; value = 16'h1234; en = 1'b1; dp_mask = 4'b0000;
        test_reset();
        test_scan();
        test_blanking();
        test_snapshot();
        test_enable_dp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
